raster_stream_tagger: RTL and testbench

- Parametrised pixel-stream stage that tags each accepted pixel with its raster position and frame-boundary flags.
- Sits between a pixel source (camera/loader) and per-pixel processing (filters, dumpers), replacing free-running row/col counters.
- Adds valid/ready backpressure, runtime re-synchronisation, a frame counter and a frame-latched region-of-interest (ROI) flag.
- One-entry registered output, so it adds a single cycle of latency.

---
 rtl/raster_stream_tagger.sv | 168 ++++++++++++++++
 tb/tb_raster_stream_tagger.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_stream_tagger.sv
// raster_stream_tagger
//   Pixel-stream stage that tags every accepted pixel with its raster
//   position (row, col), line/frame boundary flags and a frame-latched
//   region-of-interest flag. It keeps a frame counter and reports
//   re-synchronisation events that truncate a frame. The output is a single
//   registered entry, so the stage adds one cycle of latency and sustains
//   one pixel per clock.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready = !out_valid || out_ready)
//   in_data                  pixel, channel 0 in the LSBs
//   sync_clear               marks the accepted beat as pixel (0,0) of a new frame
//   roi_{col,row}_{min,max}  inclusive ROI bounds, sampled at each frame start
//   out_valid/out_ready      output handshake
//   out_data, out_row/col    registered pixel and its position
//   out_sol/eol/sof/eof      start/end of line, first/last pixel of frame
//   out_in_roi               pixel lies inside the ROI latched for its frame
//   frame_count              completed frames, wraps
//   sync_err                 one-cycle pulse: sync_clear arrived mid-frame
module raster_stream_tagger #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int COORD_W  = 13,
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 8,
  parameter int FRAME_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         sync_clear,
  input  logic [COORD_W-1:0]           roi_col_min,
  input  logic [COORD_W-1:0]           roi_col_max,
  input  logic [COORD_W-1:0]           roi_row_min,
  input  logic [COORD_W-1:0]           roi_row_max,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [COORD_W-1:0]           out_row,
  output logic [COORD_W-1:0]           out_col,
  output logic                         out_sol,
  output logic                         out_eol,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic                         out_in_roi,
  output logic [FRAME_W-1:0]           frame_count,
  output logic                         sync_err
);

  localparam int PIX_W = CHANNELS * DATA_W;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT - 1);

  logic               out_valid_q;
  logic [PIX_W-1:0]   out_data_q;
  logic [COORD_W-1:0] out_row_q, out_col_q;
  logic               out_sol_q, out_eol_q, out_sof_q, out_eof_q, out_in_roi_q;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  logic               sync_err_q, sync_err_d;
  logic [COORD_W-1:0] row_c_q, row_c_d, col_c_q, col_c_d;
  logic [COORD_W-1:0] roi_cmin_q, roi_cmax_q, roi_rmin_q, roi_rmax_q;

  logic               accept;
  logic               at_origin;
  logic               tag_origin;
  logic [COORD_W-1:0] tag_row, tag_col;
  logic [COORD_W-1:0] cmin_use, cmax_use, rmin_use, rmax_use;
  logic               tag_in_roi;
  logic               frame_done;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    at_origin  = (row_c_q == '0) && (col_c_q == '0);
    tag_row    = sync_clear ? '0 : row_c_q;
    tag_col    = sync_clear ? '0 : col_c_q;
    tag_origin = sync_clear || at_origin;

    // A frame-start beat already uses the bounds being latched on it.
    cmin_use = tag_origin ? roi_col_min : roi_cmin_q;
    cmax_use = tag_origin ? roi_col_max : roi_cmax_q;
    rmin_use = tag_origin ? roi_row_min : roi_rmin_q;
    rmax_use = tag_origin ? roi_row_max : roi_rmax_q;
    tag_in_roi = (tag_row >= rmin_use) && (tag_row <= rmax_use) &&
                 (tag_col >= cmin_use) && (tag_col <= cmax_use);

    // Position advance is computed from the tag, so a resync restarts the
    // raster and the truncated frame never reaches the wrap point.
    frame_done = 1'b0;
    if (tag_col != LAST_COL) begin
      row_c_d = tag_row;
      col_c_d = tag_col + COORD_W'(1);
    end else if (tag_row != LAST_ROW) begin
      row_c_d = tag_row + COORD_W'(1);
      col_c_d = '0;
    end else begin
      row_c_d    = '0;
      col_c_d    = '0;
      frame_done = 1'b1;
    end

    frame_count_d = frame_done ? frame_count_q + FRAME_W'(1) : frame_count_q;
    sync_err_d    = accept && sync_clear && !at_origin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_sol_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      out_in_roi_q  <= 1'b0;
      frame_count_q <= '0;
      sync_err_q    <= 1'b0;
      row_c_q       <= '0;
      col_c_q       <= '0;
      roi_cmin_q    <= '0;
      roi_cmax_q    <= LAST_COL;
      roi_rmin_q    <= '0;
      roi_rmax_q    <= LAST_ROW;
    end else begin
      sync_err_q <= sync_err_d;
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= in_data;
        out_row_q     <= tag_row;
        out_col_q     <= tag_col;
        out_sol_q     <= (tag_col == '0);
        out_eol_q     <= (tag_col == LAST_COL);
        out_sof_q     <= tag_origin;
        out_eof_q     <= (tag_row == LAST_ROW) && (tag_col == LAST_COL);
        out_in_roi_q  <= tag_in_roi;
        row_c_q       <= row_c_d;
        col_c_q       <= col_c_d;
        frame_count_q <= frame_count_d;
        if (tag_origin) begin
          roi_cmin_q <= roi_col_min;
          roi_cmax_q <= roi_col_max;
          roi_rmin_q <= roi_row_min;
          roi_rmax_q <= roi_row_max;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_sol     = out_sol_q;
  assign out_eol     = out_eol_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign out_in_roi  = out_in_roi_q;
  assign frame_count = frame_count_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_raster_stream_tagger.sv
module tb_raster_stream_tagger;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int CW  = 13;
  localparam int FW  = 2;
  localparam int PW  = 24;
  localparam int NPX = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          sync_clear = 1'b0;
  logic [CW-1:0] roi_col_min = '0, roi_col_max = CW'(W - 1);
  logic [CW-1:0] roi_row_min = '0, roi_row_max = CW'(H - 1);
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] out_data;
  logic [CW-1:0] out_row, out_col;
  logic          out_sol, out_eol, out_sof, out_eof, out_in_roi;
  logic [FW-1:0] frame_count;
  logic          sync_err;

  raster_stream_tagger #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CHANNELS(3), .DATA_W(8), .FRAME_W(FW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sync_clear(sync_clear),
    .roi_col_min(roi_col_min), .roi_col_max(roi_col_max),
    .roi_row_min(roi_row_min), .roi_row_max(roi_row_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col),
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .out_eof(out_eof),
    .out_in_roi(out_in_roi), .frame_count(frame_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a linear pixel index within the frame; position and
  // flags are derived from it with division/modulo.
  int            idx, m_fc, m_row, m_col;
  logic          m_valid, m_sol, m_eol, m_sof, m_eof, m_roi, m_serr;
  logic [PW-1:0] m_data;
  int            lr_cmin, lr_cmax, lr_rmin, lr_rmax;
  logic          exp_rdy, obs_rdy;

  task automatic model_reset();
    idx = 0; m_fc = 0; m_row = 0; m_col = 0;
    m_valid = 0; m_data = '0;
    m_sol = 0; m_eol = 0; m_sof = 0; m_eof = 0; m_roi = 0; m_serr = 0;
    lr_cmin = 0; lr_cmax = W - 1; lr_rmin = 0; lr_rmax = H - 1;
  endtask

  function automatic logic [58:0] obs_vec();
    return {out_valid, out_data, out_row, out_col, out_sol, out_eol, out_sof,
            out_eof, out_in_roi, frame_count, sync_err};
  endfunction

  function automatic logic [58:0] exp_vec();
    return {m_valid, m_data, CW'(m_row), CW'(m_col), m_sol, m_eol, m_sof,
            m_eof, m_roi, FW'(m_fc), m_serr};
  endfunction

  // One clock: drive inputs, observe in_ready, advance the model at the edge,
  // then leave the caller 1 time unit after the edge to sample outputs.
  task automatic cycle(input logic v, input logic sc, input logic rdy);
    logic acc;
    in_valid = v; sync_clear = sc; out_ready = rdy; in_data = PW'($urandom);
    #1;
    obs_rdy = in_ready;
    exp_rdy = !m_valid || rdy;
    @(posedge clk);
    acc = v && exp_rdy;
    m_serr = 0;
    if (acc) begin
      if (sc && idx != 0) m_serr = 1;
      if (sc) idx = 0;
      if (idx == 0) begin
        lr_cmin = int'(roi_col_min); lr_cmax = int'(roi_col_max);
        lr_rmin = int'(roi_row_min); lr_rmax = int'(roi_row_max);
      end
      m_row = idx / W; m_col = idx % W;
      m_valid = 1; m_data = in_data;
      m_sol = (m_col == 0); m_eol = (m_col == W - 1);
      m_sof = (idx == 0);   m_eof = (idx == NPX - 1);
      m_roi = (m_row >= lr_rmin) && (m_row <= lr_rmax) &&
              (m_col >= lr_cmin) && (m_col <= lr_cmax);
      idx++;
      if (idx == NPX) begin idx = 0; m_fc = (m_fc + 1) % (1 << FW); end
    end else if (rdy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; sync_clear = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 0;
    #2;
    checks++;
    if (obs_vec() !== 59'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", obs_vec());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    do_reset();
  endtask

  task automatic test_frame();
    do_reset();
    for (int i = 0; i < NPX + 1; i++) begin
      cycle(1, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL frame_beat%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 0 || i == NPX) begin
        checks++;
        if ({out_sof, out_row, out_col} !== {1'b1, CW'(0), CW'(0)}) begin
          errors++; $display("FAIL frame_sof%0d got %b/%0d/%0d want 1/0/0", i, out_sof, out_row, out_col);
        end
      end
      if (i == NPX - 1) begin
        checks++;
        if ({out_eof, out_eol, out_row, out_col, frame_count} !== {1'b1, 1'b1, CW'(2), CW'(3), FW'(1)}) begin
          errors++; $display("FAIL frame_eof got eof%b eol%b %0d/%0d fc%0d want 1 1 2/3 fc1",
                             out_eof, out_eol, out_row, out_col, frame_count);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pat = 4'b1001;
    logic [58:0] prev;
    logic        stall, v;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      prev  = obs_vec();
      stall = out_valid && !pat[i % 4];
      v     = 1'($urandom_range(0, 1));
      cycle(v, 0, pat[i % 4]);
      checks++;
      if (obs_rdy !== exp_rdy) begin
        errors++; $display("FAIL bp_in_ready%0d got %b want %b", i, obs_rdy, exp_rdy);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_beat%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (stall) begin
        checks++;
        if (obs_vec() !== prev) begin
          errors++; $display("FAIL bp_hold%0d got %h want %h", i, obs_vec(), prev);
        end
      end
    end
  endtask

  task automatic test_sync();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, (i == 5), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL sync_beat%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if ({out_sof, out_row, out_col, sync_err, frame_count} !== {1'b1, CW'(0), CW'(0), 1'b1, FW'(0)}) begin
          errors++; $display("FAIL sync_resync got sof%b %0d/%0d err%b fc%0d want 1 0/0 1 0",
                             out_sof, out_row, out_col, sync_err, frame_count);
        end
      end
      if (i == 6) begin
        checks++;
        if (sync_err !== 1'b0) begin
          errors++; $display("FAIL sync_pulse_len got %b want 0", sync_err);
        end
      end
    end
    // sync_clear on a beat already at (0,0) is silent
    do_reset();
    cycle(1, 1, 1);
    checks++;
    if ({out_sof, sync_err} !== 2'b10) begin
      errors++; $display("FAIL sync_origin got sof%b err%b want 1 0", out_sof, sync_err);
    end
    // sync_clear without accept is ignored
    cycle(1, 0, 1);
    cycle(0, 1, 1);
    cycle(1, 0, 1);
    checks++;
    if (obs_vec() !== exp_vec() || out_col !== CW'(2) || sync_err !== 1'b0) begin
      errors++; $display("FAIL sync_noaccept got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_roi();
    int hits = 0;
    logic want;
    do_reset();
    roi_col_min = 1; roi_col_max = 2; roi_row_min = 1; roi_row_max = 1;
    for (int i = 0; i < NPX + 1; i++) begin
      if (i == 3) begin
        roi_col_min = 0; roi_col_max = 3; roi_row_min = 0; roi_row_max = 2;
      end
      cycle(1, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL roi_beat%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      want = (i < NPX) ? ((i / W == 1) && (i % W == 1 || i % W == 2)) : 1'b1;
      checks++;
      if (out_in_roi !== want) begin
        errors++; $display("FAIL roi_flag%0d got %b want %b", i, out_in_roi, want);
      end
      if (i < NPX && out_in_roi) hits++;
    end
    checks++;
    if (hits != 2) begin
      errors++; $display("FAIL roi_hits got %0d want 2", hits);
    end
    // an inverted axis disables the flag for the whole frame
    do_reset();
    roi_col_min = 3; roi_col_max = 1;
    for (int i = 0; i < NPX; i++) begin
      cycle(1, 0, 1);
      checks++;
      if (out_in_roi !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL roi_inverted%0d got %b want 0", i, out_in_roi);
      end
    end
    roi_col_min = 0; roi_col_max = CW'(W - 1);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < NPX + 10; i++) cycle(1, 0, 1);
    checks++;
    if ({out_valid, out_row, out_col, frame_count} !== {1'b1, CW'(2), CW'(1), FW'(1)}) begin
      errors++; $display("FAIL areset_pre got v%b %0d/%0d fc%0d want 1 2/1 1",
                         out_valid, out_row, out_col, frame_count);
    end
    in_valid = 0;
    #2 reset = 1;
    #1;
    checks++;
    if (obs_vec() !== 59'd0) begin
      errors++; $display("FAIL areset_noclk got %h want 0", obs_vec());
    end
    @(posedge clk);
    #3 reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1, 0, 1);
    checks++;
    if ({out_sof, out_row, out_col, frame_count} !== {1'b1, CW'(0), CW'(0), FW'(0)} ||
        obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL areset_post got sof%b %0d/%0d fc%0d want 1 0/0 0",
                         out_sof, out_row, out_col, frame_count);
    end
  endtask

  task automatic test_frame_count();
    logic [FW-1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < NPX; p++) begin
        cycle(1, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL fc_beat%0d_%0d got %h want %h", f, p, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (frame_count !== seq[f]) begin
        errors++; $display("FAIL fc_frame%0d got %0d want %0d", f, frame_count, seq[f]);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_frame();
    test_back_to_back();
    test_sync();
    test_roi();
    test_async_reset();
    test_frame_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
